// File: rtl/fp_dot_sequencer.sv
// Dot-product sequencer wrapped around a pipelined FP MAC. Only one MAC op is in flight, and each result is captured MAC_LATENCY cycles after issue.
// The result appears len*(MAC_LATENCY+1)+1 cycles after start. Operands are throttled by in_ready, and the result is held until out_ready.
module fp_dot_sequencer #(
  parameter int SIG_WIDTH   = 23,
  parameter int EXP_WIDTH   = 8,
  parameter int MAC_LATENCY = 4,
  parameter int MAX_LEN     = 16,
  localparam int W          = SIG_WIDTH + EXP_WIDTH + 1,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [2:0]       rnd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic [W-1:0]     mac_a,
  output logic [W-1:0]     mac_b,
  output logic [W-1:0]     mac_c,
  output logic [2:0]       mac_rnd,
  output logic             mac_dg_ctrl,
  input  logic [W-1:0]     mac_z,
  input  logic [7:0]       mac_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_z,
  output logic [7:0]       out_status,
  output logic             busy
);

  localparam int TMR_W = 3;
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(MAC_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [7:0]         sts_q, sts_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       c_q, c_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       out_z_q, out_z_d;
  logic [7:0]         out_status_q, out_status_d;
  logic               busy_q, busy_d;

  logic               fire;
  logic [LEN_W-1:0]   len_eff;

  assign fire    = in_ready_q & in_valid;
  assign len_eff = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

  // Operands reach the MAC in the accept cycle itself; afterwards the MAC inputs hold their last issued values.
  assign mac_a       = fire ? in_a  : a_q;
  assign mac_b       = fire ? in_b  : b_q;
  assign mac_c       = fire ? acc_q : c_q;
  assign mac_dg_ctrl = fire;
  assign mac_rnd     = rnd;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_z      = out_z_q;
  assign out_status = out_status_q;
  assign busy       = busy_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    acc_d        = acc_q;
    sts_d        = sts_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_z_d      = out_z_q;
    out_status_d = out_status_q;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = len_eff;
          acc_d  = '0;
          sts_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (len_eff == '0) begin
            state_d      = S_DONE;
            out_valid_d  = 1'b1;
            out_z_d      = '0;
            out_status_d = '0;
          end else begin
            state_d    = S_ISSUE;
            in_ready_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (fire) begin
          a_d        = in_a;
          b_d        = in_b;
          c_d        = acc_q;
          cnt_d      = cnt_q + LEN_W'(1);
          tmr_d      = TMR_INIT;
          in_ready_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tmr_q == '0) begin
          acc_d = mac_z;
          sts_d = sts_q | mac_status;
          if (cnt_q == len_q) begin
            state_d      = S_DONE;
            out_valid_d  = 1'b1;
            out_z_d      = mac_z;
            out_status_d = sts_q | mac_status;
          end else begin
            state_d    = S_ISSUE;
            in_ready_d = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d      = S_IDLE;
          out_valid_d  = 1'b0;
          out_z_d      = '0;
          out_status_d = '0;
          busy_d       = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      acc_q        <= '0;
      sts_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_z_q      <= '0;
      out_status_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      acc_q        <= acc_d;
      sts_q        <= sts_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_z_q      <= out_z_d;
      out_status_q <= out_status_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_fp_dot_sequencer.sv
// Directed bench for fp_dot_sequencer with a table-driven MAC stand-in of fixed latency.
module tb_fp_dot_sequencer;
  localparam int LAT = 4;
  localparam logic [31:0] ONE = 32'h3F800000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  len;
  logic [2:0]  rnd;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] mac_a, mac_b, mac_c, mac_z;
  logic [2:0]  mac_rnd;
  logic        mac_dg_ctrl;
  logic [7:0]  mac_status;
  logic        out_valid, out_ready, busy;
  logic [31:0] out_z;
  logic [7:0]  out_status;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] a_arr [0:31];
  logic [31:0] b_arr [0:31];
  int          iss_cyc [0:31];
  logic [31:0] iss_c [0:31];
  int          n_iss, ov_cyc;
  logic [31:0] got_z;
  logic [7:0]  got_st;
  bit          timed_out, unstable, busy_drop, bad_dg, post_busy, post_valid;

  always #5 clk = ~clk;

  fp_dot_sequencer #(.SIG_WIDTH(23), .EXP_WIDTH(8), .MAC_LATENCY(LAT), .MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .rnd(rnd),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_rnd(mac_rnd), .mac_dg_ctrl(mac_dg_ctrl),
    .mac_z(mac_z), .mac_status(mac_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_status(out_status), .busy(busy)
  );

  function automatic logic [31:0] int_fp(input int n);
    int p;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 31; i++) if ((n >> i) != 0) p = i;
    m = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  // Only operand triples used by the scenarios are known; anything else returns a poison value.
  function automatic logic [39:0] mac_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [95:0] k;
    k = {a, b, c};
    case (k)
      {32'h3F800000, 32'h40800000, 32'h00000000}: return {32'h40800000, 8'h00};
      {32'h40000000, 32'h40A00000, 32'h40800000}: return {32'h41600000, 8'h00};
      {32'h40400000, 32'h40C00000, 32'h41600000}: return {32'h42000000, 8'h00};
      {32'h7F7FFFFF, 32'h40000000, 32'h00000000}: return {32'h7F800000, 8'h32};
      {32'h00000000, 32'h00000000, 32'h7F800000}: return {32'h7F800000, 8'h02};
      {32'h40000000, 32'h40400000, 32'h00000000}: return {32'h40C00000, 8'h00};
      default: ;
    endcase
    if (a == ONE && b == ONE)
      for (int i = 0; i < 16; i++) if (c == int_fp(i)) return {int_fp(i + 1), 8'h00};
    return {32'hDEADBEEF, 8'h80};
  endfunction

  logic [31:0] pz [0:LAT-1];
  logic [7:0]  ps [0:LAT-1];
  always @(posedge clk) begin
    if (mac_dg_ctrl) {pz[0], ps[0]} <= mac_fn(mac_a, mac_b, mac_c);
    else begin pz[0] <= 32'hDEADBEEF; ps[0] <= 8'h80; end
    for (int i = 1; i < LAT; i++) begin pz[i] <= pz[i-1]; ps[i] <= ps[i-1]; end
  end
  assign mac_z      = pz[LAT-1];
  assign mac_status = ps[LAT-1];

  // Drives one run from the start pulse to the output handshake and records what was observed.
  task automatic run_seq(input int len_i, input int n_offer, input int gap, input int hold, input bit poke);
    int idx = 0, gapc = 0, cyc = 0, held = 0;
    bit done = 0;
    n_iss = 0; ov_cyc = -1; timed_out = 0; unstable = 0; busy_drop = 0; bad_dg = 0;
    @(posedge clk); #1;
    start = 1'b1; len = 5'(len_i); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      in_valid = (idx < n_offer) && (gapc == 0);
      in_a = a_arr[idx]; in_b = b_arr[idx];
      if (ov_cyc >= 0) begin
        out_ready = (held >= hold);
        start = poke && (held == 2);
      end
      @(negedge clk);
      if (mac_dg_ctrl) begin
        if (!(in_ready && in_valid)) bad_dg = 1;
        iss_cyc[n_iss] = cyc; iss_c[n_iss] = mac_c; n_iss++; idx++; gapc = gap;
      end else if (gapc > 0) gapc--;
      if (out_valid) begin
        if (ov_cyc < 0) begin ov_cyc = cyc; got_z = out_z; got_st = out_status; end
        else if (out_z !== got_z || out_status !== got_st) unstable = 1;
        if (!busy) busy_drop = 1;
        if (out_ready) done = 1; else held++;
      end
      if (cyc > 2000) begin timed_out = 1; done = 1; end
    end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    post_busy = busy; post_valid = out_valid;
  endtask

  task automatic test_reset;
    n_checks++; if ({in_ready, out_valid, mac_dg_ctrl, busy} !== 4'b0) begin n_errors++; $display("FAIL reset_ctrl got %b exp 0000", {in_ready, out_valid, mac_dg_ctrl, busy}); end
    n_checks++; if (out_z !== 32'h0) begin n_errors++; $display("FAIL reset_out_z got %h exp 00000000", out_z); end
    n_checks++; if (out_status !== 8'h0) begin n_errors++; $display("FAIL reset_out_status got %h exp 00", out_status); end
    rnd = 3'b101; #1;
    n_checks++; if (mac_rnd !== 3'b101) begin n_errors++; $display("FAIL rnd_pass got %b exp 101", mac_rnd); end
    rnd = 3'b000;
  endtask

  task automatic test_basic;
    a_arr[0] = 32'h3F800000; a_arr[1] = 32'h40000000; a_arr[2] = 32'h40400000;
    b_arr[0] = 32'h40800000; b_arr[1] = 32'h40A00000; b_arr[2] = 32'h40C00000;
    run_seq(3, 3, 0, 0, 0);
    n_checks++; if (timed_out !== 0) begin n_errors++; $display("FAIL basic_timeout got %0d exp 0", timed_out); end
    n_checks++; if (n_iss !== 3) begin n_errors++; $display("FAIL basic_n_issue got %0d exp 3", n_iss); end
    n_checks++; if (iss_cyc[0] !== 1) begin n_errors++; $display("FAIL basic_issue0 got %0d exp 1", iss_cyc[0]); end
    n_checks++; if (iss_cyc[1] !== 6) begin n_errors++; $display("FAIL basic_issue1 got %0d exp 6", iss_cyc[1]); end
    n_checks++; if (iss_cyc[2] !== 11) begin n_errors++; $display("FAIL basic_issue2 got %0d exp 11", iss_cyc[2]); end
    n_checks++; if (iss_c[1] !== 32'h40800000) begin n_errors++; $display("FAIL basic_c1 got %h exp 40800000", iss_c[1]); end
    n_checks++; if (iss_c[2] !== 32'h41600000) begin n_errors++; $display("FAIL basic_c2 got %h exp 41600000", iss_c[2]); end
    n_checks++; if (ov_cyc !== 16) begin n_errors++; $display("FAIL basic_out_cycle got %0d exp 16", ov_cyc); end
    n_checks++; if (got_z !== 32'h42000000) begin n_errors++; $display("FAIL basic_out_z got %h exp 42000000", got_z); end
    n_checks++; if (got_st !== 8'h00) begin n_errors++; $display("FAIL basic_status got %h exp 00", got_st); end
    n_checks++; if ({post_busy, post_valid, bad_dg} !== 3'b000) begin n_errors++; $display("FAIL basic_idle_after got %b exp 000", {post_busy, post_valid, bad_dg}); end
  endtask

  task automatic test_zero_len;
    run_seq(0, 0, 0, 0, 0);
    n_checks++; if (ov_cyc !== 1) begin n_errors++; $display("FAIL zero_out_cycle got %0d exp 1", ov_cyc); end
    n_checks++; if (got_z !== 32'h0) begin n_errors++; $display("FAIL zero_out_z got %h exp 00000000", got_z); end
    n_checks++; if (got_st !== 8'h0) begin n_errors++; $display("FAIL zero_status got %h exp 00", got_st); end
    n_checks++; if (n_iss !== 0) begin n_errors++; $display("FAIL zero_dg_pulses got %0d exp 0", n_iss); end
  endtask

  task automatic test_overflow;
    a_arr[0] = 32'h7F7FFFFF; b_arr[0] = 32'h40000000;
    a_arr[1] = 32'h00000000; b_arr[1] = 32'h00000000;
    run_seq(2, 2, 0, 0, 0);
    n_checks++; if (got_z !== 32'h7F800000) begin n_errors++; $display("FAIL ovf_out_z got %h exp 7F800000", got_z); end
    n_checks++; if ((got_st & 8'h12) !== 8'h12) begin n_errors++; $display("FAIL ovf_status_bits got %h exp bits 1,4 set", got_st); end
    n_checks++; if (got_st !== 8'h32) begin n_errors++; $display("FAIL ovf_status got %h exp 32", got_st); end
  endtask

  task automatic test_backpressure;
    a_arr[0] = 32'h3F800000; b_arr[0] = 32'h40800000;
    a_arr[1] = 32'h40000000; b_arr[1] = 32'h40A00000;
    run_seq(2, 2, 7, 10, 1);
    n_checks++; if (timed_out !== 0) begin n_errors++; $display("FAIL bp_timeout got %0d exp 0", timed_out); end
    n_checks++; if (iss_cyc[1] !== 9) begin n_errors++; $display("FAIL bp_issue1 got %0d exp 9", iss_cyc[1]); end
    n_checks++; if (ov_cyc !== 14) begin n_errors++; $display("FAIL bp_out_cycle got %0d exp 14", ov_cyc); end
    n_checks++; if (got_z !== 32'h41600000) begin n_errors++; $display("FAIL bp_out_z got %h exp 41600000", got_z); end
    n_checks++; if (unstable !== 0) begin n_errors++; $display("FAIL bp_stable got %0d exp 0", unstable); end
    n_checks++; if (busy_drop !== 0) begin n_errors++; $display("FAIL bp_busy_held got %0d exp 0", busy_drop); end
    n_checks++; if ({post_busy, post_valid} !== 2'b00) begin n_errors++; $display("FAIL bp_start_ignored got %b exp 00", {post_busy, post_valid}); end
  endtask

  task automatic test_reset_mid_wait;
    int seen = 0, cyc = 0;
    a_arr[0] = 32'h3F800000; a_arr[1] = 32'h40000000; a_arr[2] = 32'h40400000;
    b_arr[0] = 32'h40800000; b_arr[1] = 32'h40A00000; b_arr[2] = 32'h40C00000;
    @(posedge clk); #1;
    start = 1'b1; len = 5'd3;
    while (seen < 2 && cyc < 100) begin
      @(posedge clk); #1;
      start = 1'b0; cyc++;
      in_valid = 1'b1; in_a = a_arr[seen]; in_b = b_arr[seen];
      @(negedge clk);
      if (mac_dg_ctrl) seen++;
    end
    n_checks++; if (seen !== 2) begin n_errors++; $display("FAIL rst_reach_wait got %0d issues exp 2", seen); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    n_checks++; if ({in_ready, out_valid, out_z, out_status, mac_dg_ctrl, busy} !== 44'h0) begin n_errors++; $display("FAIL rst_async got %h exp 0", {in_ready, out_valid, out_z, out_status, mac_dg_ctrl, busy}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    a_arr[0] = 32'h40000000; b_arr[0] = 32'h40400000;
    run_seq(1, 1, 0, 0, 0);
    n_checks++; if (ov_cyc !== 6) begin n_errors++; $display("FAIL rst_rerun_cycle got %0d exp 6", ov_cyc); end
    n_checks++; if (got_z !== 32'h40C00000) begin n_errors++; $display("FAIL rst_rerun_z got %h exp 40C00000", got_z); end
    n_checks++; if (got_st !== 8'h00) begin n_errors++; $display("FAIL rst_rerun_status got %h exp 00", got_st); end
  endtask

  task automatic test_clamp;
    for (int i = 0; i < 17; i++) begin a_arr[i] = ONE; b_arr[i] = ONE; end
    run_seq(17, 17, 0, 0, 0);
    n_checks++; if (n_iss !== 16) begin n_errors++; $display("FAIL clamp_accepted got %0d exp 16", n_iss); end
    n_checks++; if (got_z !== 32'h41800000) begin n_errors++; $display("FAIL clamp_out_z got %h exp 41800000", got_z); end
    n_checks++; if (ov_cyc !== 81) begin n_errors++; $display("FAIL clamp_out_cycle got %0d exp 81", ov_cyc); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; rnd = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_basic;
    test_zero_len;
    test_overflow;
    test_backpressure;
    test_reset_mid_wait;
    test_clamp;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
